// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM generator with shadowed, frame-synchronous duty control
module pwm_multi_ch #(
  parameter  int CH        = 4,
  parameter  int PERIOD    = 20,
  parameter  int DUTY_INIT = 10,
  parameter  int STEP      = 1,
  parameter  int MODE      = 0,
  localparam int CW        = $clog2(PERIOD + 1),
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CH-1:0]    inc,
  input  logic [CH-1:0]    dec,
  input  logic             load_en,
  input  logic [CHW-1:0]   load_ch,
  input  logic [CW-1:0]    load_val,
  output logic [CH-1:0]    pwm_out,
  output logic [CH*CW-1:0] duty_q,
  output logic             frame_start
);

  localparam logic [CW:0]   PER_X  = (CW+1)'(PERIOD);
  localparam logic [CW:0]   STEP_X = (CW+1)'(STEP);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] INIT   = CW'(DUTY_INIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_dn_q, dir_dn_d;
  logic          fs_now, fs_next;
  logic [CH-1:0] inc_s1_q, inc_s2_q, inc_prev_q;
  logic [CH-1:0] dec_s1_q, dec_s2_q, dec_prev_q;
  logic [CH-1:0] inc_pls, dec_pls;
  logic [CH-1:0] pwm_q, pwm_d;
  logic          frame_start_q;
  logic [CW-1:0] duty_sh_q  [CH];
  logic [CW-1:0] duty_sh_d  [CH];
  logic [CW-1:0] duty_act_q [CH];

  function automatic logic [CW-1:0] clamp(input logic [CW:0] v);
    return (v > PER_X) ? PER_X[CW-1:0] : v[CW-1:0];
  endfunction

  // Center-aligned mode dwells one extra cycle at each end while dir flips.
  always_comb begin
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;
    if (MODE == 0) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end else if (!dir_dn_q) begin
      if (cnt_q == LAST) dir_dn_d = 1'b1;
      else               cnt_d    = cnt_q + ONE;
    end else begin
      if (cnt_q == '0) dir_dn_d = 1'b0;
      else             cnt_d    = cnt_q - ONE;
    end
  end

  assign fs_now  = (cnt_q == '0) && !dir_dn_q;
  assign fs_next = (cnt_d == '0) && !dir_dn_d;
  assign inc_pls = inc_s2_q & ~inc_prev_q;
  assign dec_pls = dec_s2_q & ~dec_prev_q;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      duty_sh_d[i] = duty_sh_q[i];
      pwm_d[i]     = (cnt_q < duty_act_q[i]);
      if (load_en && (load_ch == CHW'(i))) begin
        duty_sh_d[i] = clamp({1'b0, load_val});
      end else if (inc_pls[i] && !dec_pls[i]) begin
        duty_sh_d[i] = clamp({1'b0, duty_sh_q[i]} + STEP_X);
      end else if (dec_pls[i] && !inc_pls[i]) begin
        duty_sh_d[i] = ({1'b0, duty_sh_q[i]} < STEP_X) ? '0 : duty_sh_q[i] - STEP_X[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      dir_dn_q      <= 1'b0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      inc_s1_q      <= '0;
      inc_s2_q      <= '0;
      inc_prev_q    <= '0;
      dec_s1_q      <= '0;
      dec_s2_q      <= '0;
      dec_prev_q    <= '0;
      for (int i = 0; i < CH; i++) begin
        duty_sh_q[i]  <= INIT;
        duty_act_q[i] <= INIT;
      end
    end else begin
      cnt_q         <= cnt_d;
      dir_dn_q      <= dir_dn_d;
      pwm_q         <= pwm_d;
      frame_start_q <= fs_now;
      inc_s1_q      <= inc;
      inc_s2_q      <= inc_s1_q;
      inc_prev_q    <= inc_s2_q;
      dec_s1_q      <= dec;
      dec_s2_q      <= dec_s1_q;
      dec_prev_q    <= dec_s2_q;
      for (int i = 0; i < CH; i++) begin
        duty_sh_q[i] <= duty_sh_d[i];
        // Active duty samples the pre-update shadow, so a same-edge write waits a frame.
        if (fs_next) duty_act_q[i] <= duty_sh_q[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_duty
    assign duty_q[g*CW +: CW] = duty_sh_q[g];
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - randomized self-checking bench for pwm_multi_ch against a frame-level duty model
module tb_pwm_multi_ch;

  localparam int P = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, ld_en0;
  logic [3:0]  inc0, dec0, pwm0;
  logic [1:0]  ld_ch0;
  logic [4:0]  ld_val0;
  logic [19:0] dq0;
  logic        fs0;

  logic        rst1, ld_en1;
  logic [2:0]  inc1, dec1, pwm1;
  logic [1:0]  ld_ch1;
  logic [4:0]  ld_val1;
  logic [14:0] dq1;
  logic        fs1;

  pwm_multi_ch #(.CH(4), .PERIOD(P), .DUTY_INIT(10), .STEP(1), .MODE(0)) dut0 (
    .clk_in(clk), .rst(rst0), .inc(inc0), .dec(dec0), .load_en(ld_en0), .load_ch(ld_ch0),
    .load_val(ld_val0), .pwm_out(pwm0), .duty_q(dq0), .frame_start(fs0));

  pwm_multi_ch #(.CH(3), .PERIOD(P), .DUTY_INIT(3), .STEP(1), .MODE(1)) dut1 (
    .clk_in(clk), .rst(rst1), .inc(inc1), .dec(dec1), .load_en(ld_en1), .load_ch(ld_ch1),
    .load_val(ld_val1), .pwm_out(pwm1), .duty_q(dq1), .frame_start(fs1));

  int total = 0;
  int bad   = 0;
  int md  [4];
  int md1 [3];
  logic [3:0] cap0 [2*P];
  logic [2:0] cap1 [2*P];
  logic       capfs [2*P];

  // Edge-aligned: high for the first `duty` positions of a frame.
  function automatic logic [3:0] exp0(input int j);
    logic [3:0] e;
    for (int c = 0; c < 4; c++) e[c] = (j < md[c]);
    return e;
  endfunction

  // Center-aligned: high where distance to the nearer frame edge is below duty.
  function automatic logic [2:0] exp1(input int j);
    logic [2:0] e;
    int d;
    d = (j < P) ? j : 2*P - 1 - j;
    for (int c = 0; c < 3; c++) e[c] = (d < md1[c]);
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v < 0) ? 0 : (v > P) ? P : v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic capture0(output int n);
    n = 0;
    while (!fs0 && n < 100) begin @(negedge clk); n++; end
    if (!fs0) n = -1;
    total++;
    if (n < 0) begin bad++; $display("FAIL fs0_timeout waited=100 required=<100"); end
    cap0[0] = pwm0; capfs[0] = fs0;
    for (int j = 1; j < P; j++) begin @(negedge clk); cap0[j] = pwm0; capfs[j] = fs0; end
  endtask

  task automatic capture1(output int n);
    n = 0;
    while (!fs1 && n < 200) begin @(negedge clk); n++; end
    if (!fs1) n = -1;
    total++;
    if (n < 0) begin bad++; $display("FAIL fs1_timeout waited=200 required=<200"); end
    cap1[0] = pwm1; capfs[0] = fs1;
    for (int j = 1; j < 2*P; j++) begin @(negedge clk); cap1[j] = pwm1; capfs[j] = fs1; end
  endtask

  task automatic pulse0(input int ch, input bit up, input int hi, input int lo);
    if (up) inc0[ch] = 1'b1; else dec0[ch] = 1'b1;
    cyc(hi);
    inc0[ch] = 1'b0; dec0[ch] = 1'b0;
    cyc(lo);
    md[ch] = sat(up ? md[ch] + 1 : md[ch] - 1);
  endtask

  task automatic test_reset();
    int n;
    rst0 = 1'b0;
    cyc(3);
    total++; if (pwm0 !== 4'b0) begin bad++; $display("FAIL rst_pwm got=%b want=0000", pwm0); end
    total++; if (fs0 !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", fs0); end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (dq0[c*5 +: 5] !== 5'd10) begin bad++; $display("FAIL rst_duty ch%0d got=%0d want=10", c, dq0[c*5 +: 5]); end
    end
    rst0 = 1'b1;
    @(negedge clk);
    total++; if (fs0 !== 1'b1) begin bad++; $display("FAIL first_frame_start got=%b want=1", fs0); end
    for (int f = 0; f < 2; f++) begin
      capture0(n);
      if (f == 1) begin
        total++; if (n !== 1) begin bad++; $display("FAIL period0 gap=%0d want=1", n); end
      end
      for (int j = 0; j < P; j++) begin
        total++;
        if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL dflt_pwm pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
        if (j > 0) begin
          total++;
          if (capfs[j] !== 1'b0) begin bad++; $display("FAIL dflt_fs pos=%0d got=1 want=0", j); end
        end
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    for (int k = 0; k < 12; k++) pulse0(0, 1'b1, 3, 3);
    total++; if (dq0[4:0] !== 5'(md[0])) begin bad++; $display("FAIL inc_sat got=%0d want=%0d", dq0[4:0], md[0]); end
    for (int f = 0; f < 2; f++) begin
      capture0(n);
      for (int j = 0; j < P; j++) begin
        total++;
        if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL full_pwm pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
      end
    end
    for (int k = 0; k < 25; k++) pulse0(0, 1'b0, 3, 3);
    total++; if (dq0[4:0] !== 5'(md[0])) begin bad++; $display("FAIL dec_sat got=%0d want=%0d", dq0[4:0], md[0]); end
    for (int f = 0; f < 2; f++) begin
      capture0(n);
      for (int j = 0; j < P; j++) begin
        total++;
        if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL zero_pwm pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
      end
    end
  endtask

  task automatic test_hold();
    inc0[1] = 1'b1;
    cyc(1);
    total++; if (dq0[9:5] !== 5'd10) begin bad++; $display("FAIL hold_k got=%0d want=10", dq0[9:5]); end
    cyc(1);
    total++; if (dq0[9:5] !== 5'd10) begin bad++; $display("FAIL hold_k1 got=%0d want=10", dq0[9:5]); end
    cyc(1);
    total++; if (dq0[9:5] !== 5'd11) begin bad++; $display("FAIL hold_k2 got=%0d want=11", dq0[9:5]); end
    cyc(97);
    inc0[1] = 1'b0;
    cyc(4);
    md[1] = 11;
    total++; if (dq0[9:5] !== 5'd11) begin bad++; $display("FAIL hold_once got=%0d want=11", dq0[9:5]); end
  endtask

  task automatic test_priority();
    inc0[2] = 1'b1; dec0[2] = 1'b1;
    cyc(4);
    inc0[2] = 1'b0; dec0[2] = 1'b0;
    cyc(3);
    total++; if (dq0[14:10] !== 5'd10) begin bad++; $display("FAIL inc_dec_same got=%0d want=10", dq0[14:10]); end
    for (int r = 0; r < 2; r++) begin
      inc0[2] = 1'b1;
      cyc(2);
      ld_en0 = 1'b1; ld_ch0 = 2'd2; ld_val0 = (r == 0) ? 5'd31 : 5'd7;
      md[2] = sat(int'(ld_val0));
      cyc(1);
      ld_en0 = 1'b0;
      total++; if (dq0[14:10] !== 5'(md[2])) begin bad++; $display("FAIL load_wins r%0d got=%0d want=%0d", r, dq0[14:10], md[2]); end
      cyc(2);
      inc0[2] = 1'b0;
      cyc(3);
      total++; if (dq0[14:10] !== 5'(md[2])) begin bad++; $display("FAIL load_no_inc r%0d got=%0d want=%0d", r, dq0[14:10], md[2]); end
    end
  endtask

  task automatic test_midframe_load();
    int n;
    n = 0;
    while (!fs0 && n < 100) begin @(negedge clk); n++; end
    total++; if (!fs0) begin bad++; $display("FAIL mid_fs_timeout waited=%0d required=<100", n); end
    cap0[0] = pwm0;
    for (int j = 1; j < P; j++) begin
      @(negedge clk);
      cap0[j] = pwm0;
      if (j == 6) begin ld_en0 = 1'b1; ld_ch0 = 2'd3; ld_val0 = 5'd5; end
      if (j == 7) begin
        ld_en0 = 1'b0;
        total++; if (dq0[19:15] !== 5'd5) begin bad++; $display("FAIL mid_load got=%0d want=5", dq0[19:15]); end
      end
    end
    for (int j = 0; j < P; j++) begin
      total++;
      if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL mid_old pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
    end
    md[3] = 5;
    capture0(n);
    for (int j = 0; j < P; j++) begin
      total++;
      if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL mid_new pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
    end
  endtask

  task automatic test_random();
    int n, ch, op;
    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, 3);
      op = $urandom_range(0, 3);
      case (op)
        0: pulse0(ch, 1'b1, $urandom_range(2, 4), $urandom_range(2, 4));
        1: pulse0(ch, 1'b0, $urandom_range(2, 4), $urandom_range(2, 4));
        2: begin
          ld_en0 = 1'b1; ld_ch0 = 2'(ch); ld_val0 = 5'($urandom_range(0, 31));
          md[ch] = sat(int'(ld_val0));
          cyc(1);
          ld_en0 = 1'b0;
        end
        default: begin
          inc0[ch] = 1'b1; dec0[ch] = 1'b1;
          cyc($urandom_range(2, 4));
          inc0[ch] = 1'b0; dec0[ch] = 1'b0;
          cyc($urandom_range(2, 4));
        end
      endcase
      for (int c = 0; c < 4; c++) begin
        total++;
        if (dq0[c*5 +: 5] !== 5'(md[c])) begin bad++; $display("FAIL rand_duty it=%0d ch%0d got=%0d want=%0d", it, c, dq0[c*5 +: 5], md[c]); end
      end
    end
    cyc(2);
    capture0(n);
    for (int j = 0; j < P; j++) begin
      total++;
      if (cap0[j] !== exp0(j)) begin bad++; $display("FAIL rand_pwm pos=%0d got=%b want=%b", j, cap0[j], exp0(j)); end
    end
  endtask

  task automatic test_center();
    int n;
    rst1 = 1'b1;
    @(negedge clk);
    total++; if (fs1 !== 1'b1) begin bad++; $display("FAIL c_first_fs got=%b want=1", fs1); end
    for (int f = 0; f < 2; f++) begin
      capture1(n);
      if (f == 1) begin
        total++; if (n !== 1) begin bad++; $display("FAIL period1 gap=%0d want=1", n); end
      end
      for (int j = 0; j < 2*P; j++) begin
        total++;
        if (cap1[j] !== exp1(j)) begin bad++; $display("FAIL c_pwm pos=%0d got=%b want=%b", j, cap1[j], exp1(j)); end
        if (j > 0) begin
          total++;
          if (capfs[j] !== 1'b0) begin bad++; $display("FAIL c_fs pos=%0d got=1 want=0", j); end
        end
      end
    end
    ld_en1 = 1'b1; ld_ch1 = 2'd0; ld_val1 = 5'd15;
    cyc(1);
    ld_ch1 = 2'd3; ld_val1 = 5'd10;
    cyc(1);
    ld_en1 = 1'b0;
    md1[0] = 15;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (dq1[c*5 +: 5] !== 5'(md1[c])) begin bad++; $display("FAIL c_load ch%0d got=%0d want=%0d", c, dq1[c*5 +: 5], md1[c]); end
    end
    cyc(2);
    capture1(n);
    for (int j = 0; j < 2*P; j++) begin
      total++;
      if (cap1[j] !== exp1(j)) begin bad++; $display("FAIL c_pwm15 pos=%0d got=%b want=%b", j, cap1[j], exp1(j)); end
    end
    n = 0;
    while (!fs1 && n < 200) begin @(negedge clk); n++; end
    cyc(5);
    total++; if (pwm1 !== 3'b001) begin bad++; $display("FAIL c_pre_rst got=%b want=001", pwm1); end
    #2 rst1 = 1'b0;
    #1;
    total++; if (pwm1 !== 3'b000) begin bad++; $display("FAIL c_rst_pwm got=%b want=000", pwm1); end
    total++; if (fs1 !== 1'b0) begin bad++; $display("FAIL c_rst_fs got=%b want=0", fs1); end
    for (int c = 0; c < 3; c++) md1[c] = 3;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (dq1[c*5 +: 5] !== 5'd3) begin bad++; $display("FAIL c_rst_duty ch%0d got=%0d want=3", c, dq1[c*5 +: 5]); end
    end
    cyc(3);
    rst1 = 1'b1;
    @(negedge clk);
    total++; if (fs1 !== 1'b1) begin bad++; $display("FAIL c_restart_fs got=%b want=1", fs1); end
    capture1(n);
    total++; if (n !== 0) begin bad++; $display("FAIL c_restart_wait got=%0d want=0", n); end
    for (int j = 0; j < 2*P; j++) begin
      total++;
      if (cap1[j] !== exp1(j)) begin bad++; $display("FAIL c_restart_pwm pos=%0d got=%b want=%b", j, cap1[j], exp1(j)); end
    end
  endtask

  initial begin
    rst0 = 1'b0; inc0 = '0; dec0 = '0; ld_en0 = 1'b0; ld_ch0 = '0; ld_val0 = '0;
    rst1 = 1'b0; inc1 = '0; dec1 = '0; ld_en1 = 1'b0; ld_ch1 = '0; ld_val1 = '0;
    for (int c = 0; c < 4; c++) md[c] = 10;
    for (int c = 0; c < 3; c++) md1[c] = 3;
    test_reset();
    test_saturation();
    test_hold();
    test_priority();
    test_midframe_load();
    test_random();
    test_center();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
